rrat_commit: RTL and testbench

- Retirement register alias table, directly downstream of the ROB.
- Consumes up to SS committed instructions per cycle and updates the architectural-to-physical mapping.
- Returns each displaced physical register to the free list.
- On a mispredict flush, publishes the committed map so the front-end RAT and free list can be restored.

---
 rtl/rrat_commit.sv | 90 +++++++++
 tb/tb_rrat_commit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rrat_commit.sv
// Retirement register alias table: applies up to SS in-order commits per cycle,
// returns displaced physical registers to the free list, and publishes the map for flush recovery.
module rrat_commit #(
    parameter int SS        = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    localparam int PW       = $clog2(PHYS_REGS),
    localparam int AW       = $clog2(ARCH_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    // Commit lanes have no ready: the ROB presents them unconditionally and,
    // while busy is high, any lane presented is dropped.
    input  logic          commit_valid    [SS],
    input  logic [AW-1:0] commit_rd       [SS],
    input  logic [PW-1:0] commit_pd       [SS],
    input  logic          commit_regwrite [SS],
    input  logic          flush,
    output logic          free_valid      [SS],
    output logic [PW-1:0] free_preg       [SS],
    output logic [PW-1:0] rrat_map        [ARCH_REGS],
    output logic          restore_valid,
    output logic          busy
);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] nxt_map    [ARCH_REGS];
    logic          nxt_fvalid [SS];
    logic [PW-1:0] nxt_fpreg  [SS];

    // Lanes chain through nxt_map so a younger lane sees the older lane's write.
    always_comb begin
        nxt_map = rrat_map;
        for (int k = 0; k < SS; k++) begin
            nxt_fvalid[k] = 1'b0;
            nxt_fpreg[k]  = '0;
            if (state == RUN && commit_valid[k] && commit_regwrite[k] &&
                commit_rd[k] != '0) begin
                nxt_fvalid[k]         = 1'b1;
                nxt_fpreg[k]          = nxt_map[commit_rd[k]];
                nxt_map[commit_rd[k]] = commit_pd[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rrat_map[i] <= PW'(i);
            end
            for (int k = 0; k < SS; k++) begin
                free_valid[k] <= 1'b0;
                free_preg[k]  <= '0;
            end
            state         <= RUN;
            restore_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rrat_map   <= nxt_map;
            free_valid <= nxt_fvalid;
            free_preg  <= nxt_fpreg;
            case (state)
                RUN: begin
                    if (flush) begin
                        state         <= RECOVER;
                        restore_valid <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                RECOVER: begin
                    // A second flush here is ignored; recovery is always one cycle.
                    state         <= RUN;
                    restore_valid <= 1'b0;
                    busy          <= 1'b0;
                end
                default: begin
                    state         <= RUN;
                    restore_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rrat_commit.sv
// Directed bench for rrat_commit: hand-computed expectations for commit, free,
// same-rd chaining, x0/no-regwrite filtering, flush recovery and reset-in-recover.
module tb_rrat_commit;
    localparam int SS        = 2;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int AW        = $clog2(ARCH_REGS);

    logic          clk = 1'b0;
    logic          rst;
    logic          commit_valid    [SS];
    logic [AW-1:0] commit_rd       [SS];
    logic [PW-1:0] commit_pd       [SS];
    logic          commit_regwrite [SS];
    logic          flush;
    logic          free_valid      [SS];
    logic [PW-1:0] free_preg       [SS];
    logic [PW-1:0] rrat_map        [ARCH_REGS];
    logic          restore_valid;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    rrat_commit #(.SS(SS), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_pd(commit_pd), .commit_regwrite(commit_regwrite),
        .flush(flush), .free_valid(free_valid), .free_preg(free_preg),
        .rrat_map(rrat_map), .restore_valid(restore_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < SS; k++) begin
            commit_valid[k]    = 1'b0;
            commit_regwrite[k] = 1'b0;
            commit_rd[k]       = '0;
            commit_pd[k]       = '0;
        end
        flush = 1'b0;
    endtask

    task automatic set_lane(input int k, input int rd, input int pd, input bit rw);
        commit_valid[k]    = 1'b1;
        commit_regwrite[k] = rw;
        commit_rd[k]       = AW'(rd);
        commit_pd[k]       = PW'(pd);
    endtask

    task automatic check_identity(input string tag);
        for (int i = 0; i < ARCH_REGS; i++) begin
            check($sformatf("%s_map%0d", tag, i), int'(rrat_map[i]), i);
        end
    endtask

    // No physical register mapped twice; no freed register still mapped.
    task automatic check_injective(input string tag);
        int bad = 0;
        for (int i = 0; i < ARCH_REGS; i++)
            for (int j = i + 1; j < ARCH_REGS; j++)
                if (rrat_map[i] == rrat_map[j]) bad++;
        for (int k = 0; k < SS; k++)
            if (free_valid[k])
                for (int i = 0; i < ARCH_REGS; i++)
                    if (rrat_map[i] == free_preg[k]) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        clear_lanes();
        rst = 1'b1;
        step();
        step();
        // 1. reset state
        check_identity("rst");
        check("rst_fv0", int'(free_valid[0]), 0);
        check("rst_fv1", int'(free_valid[1]), 0);
        check("rst_restore", int'(restore_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();

        // 2. single commit on lane 0
        set_lane(0, 3, 35, 1'b1);
        step();
        clear_lanes();
        check("t2_fv0", int'(free_valid[0]), 1);
        check("t2_fv1", int'(free_valid[1]), 0);
        check("t2_fp0", int'(free_preg[0]), 3);
        check("t2_map3", int'(rrat_map[3]), 35);
        check_injective("t2_inj");
        step();
        check("t2_fv0_off", int'(free_valid[0]), 0);
        check("t2_fv1_off", int'(free_valid[1]), 0);

        // 3. same rd in both lanes
        set_lane(0, 5, 40, 1'b1);
        set_lane(1, 5, 41, 1'b1);
        step();
        clear_lanes();
        check("t3_fv0", int'(free_valid[0]), 1);
        check("t3_fv1", int'(free_valid[1]), 1);
        check("t3_fp0", int'(free_preg[0]), 5);
        check("t3_fp1", int'(free_preg[1]), 40);
        check("t3_map5", int'(rrat_map[5]), 41);
        check_injective("t3_inj");

        // 4. x0 and no-regwrite lanes are inert
        set_lane(0, 0, 50, 1'b1);
        set_lane(1, 9, 51, 1'b0);
        step();
        clear_lanes();
        check("t4_fv0", int'(free_valid[0]), 0);
        check("t4_fv1", int'(free_valid[1]), 0);
        check("t4_map0", int'(rrat_map[0]), 0);
        check("t4_map9", int'(rrat_map[9]), 9);

        // 5. flush with a same-cycle commit, then commit dropped in RECOVER
        set_lane(0, 7, 60, 1'b1);
        flush = 1'b1;
        step();
        clear_lanes();
        check("t5_restore", int'(restore_valid), 1);
        check("t5_busy", int'(busy), 1);
        check("t5_map7", int'(rrat_map[7]), 60);
        check("t5_fv0", int'(free_valid[0]), 1);
        check("t5_fp0", int'(free_preg[0]), 7);
        check_injective("t5_inj");
        set_lane(0, 8, 61, 1'b1);
        flush = 1'b1;
        step();
        clear_lanes();
        check("t5_map8", int'(rrat_map[8]), 8);
        check("t5_restore_off", int'(restore_valid), 0);
        check("t5_busy_off", int'(busy), 0);
        check("t5_fv0_drop", int'(free_valid[0]), 0);
        check("t5_map5_kept", int'(rrat_map[5]), 41);
        step();
        check("t5_restore_stay", int'(restore_valid), 0);

        // 6. reset while in RECOVER
        set_lane(0, 10, 42, 1'b1);
        set_lane(1, 11, 43, 1'b1);
        step();
        clear_lanes();
        check("t6_map10", int'(rrat_map[10]), 42);
        set_lane(0, 12, 44, 1'b1);
        flush = 1'b1;
        step();
        clear_lanes();
        check("t6_busy_pre", int'(busy), 1);
        rst = 1'b1;
        step();
        check_identity("t6");
        check("t6_busy", int'(busy), 0);
        check("t6_restore", int'(restore_valid), 0);
        check("t6_fv0", int'(free_valid[0]), 0);
        check("t6_fv1", int'(free_valid[1]), 0);
        check("t6_fp0", int'(free_preg[0]), 0);
        rst = 1'b0;
        step();
        check("t6_busy_after", int'(busy), 0);
        check("t6_restore_after", int'(restore_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
